count_seq_ctrl: RTL and testbench
=================================

// Module: count_seq_ctrl
// PURPOSE
//  Sequencer/controller for the T-FF ripple-counter datapath: accepts a
//  command (terminal count + mode), runs an N-bit counter from 0 to the limit,
//  and signals terminal count. Supports one-shot and periodic modes, pause,
//  abort and a done/ack handshake. Sits between system control logic and the
//  counter core; it is the only block that clears or enables the counter.
// PARAMETERS
//  WIDTH  8  counter and limit width in bits (>=2)
// PORTS
//  clk          in   1      clock; all state updates on the FALLING edge
//  reset        in   1      reset, asynchronous, active-high
//  cmd_valid    in   1      command offered
//  cmd_ready    out  1      command accepted when cmd_valid&cmd_ready at edge
//  cmd_limit    in   WIDTH  terminal count for the command
//  cmd_periodic in   1      1 = reload and repeat, 0 = one-shot
//  pause        in   1      level; freezes counter while in RUN/PAUSED
//  abort        in   1      level; returns controller to IDLE
//  done_ack     in   1      acknowledges done
//  count        out  WIDTH  current counter value
//  tick         out  1      one-cycle pulse: count reached limit
//  running      out  1      1 while state==RUN
//  done         out  1      one-shot finished; held until done_ack
// BEHAVIOUR
//  - Reset: state=IDLE, count=0, tick=0, done=0, running=0, limit_q=0,
//    periodic_q=0. Reset mid-run discards the command; no tick/done emitted.
//  - States: IDLE(2'b00) RUN(2'b01) PAUSED(2'b10) DONE(2'b11).
//  - cmd_ready = (state==IDLE), combinational; 0 in all other states.
//  - Priority per edge: abort > pause > terminal/increment.
//  - IDLE: on accept, latch limit_q/periodic_q, count<=0, ->RUN (1-cycle
//    latency accept->running). No accept: hold.
//  - RUN, per edge: if count==limit_q: tick<=1; periodic: count<=0, stay
//    RUN; one-shot: count holds at limit_q, done<=1, ->DONE. Else
//    count<=count+1, tick<=0. Period = limit_q+1 cycles.
//  - limit 0: count stays 0; periodic ticks every cycle; one-shot ticks
//    once on first RUN edge, then ->DONE.
//  - tick registered; high exactly one cycle per terminal (continuous for
//    limit 0 periodic). tick=0 in IDLE, PAUSED, DONE except that edge.
//  - pause=1 in RUN: ->PAUSED, count holds, tick<=0, even if count==limit_q
//    that edge (terminal deferred). PAUSED & pause=0: ->RUN, resumes next
//    edge. pause ignored in IDLE/DONE.
//  - abort=1 in RUN/PAUSED/DONE: ->IDLE, count<=0, tick<=0, done<=0.
//    abort in IDLE: no effect, cmd not accepted that edge.
//  - DONE: done=1, count=limit_q; done_ack=1 -> IDLE, done<=0, count<=0.
//    cmd_valid ignored until IDLE.
//  - running = (state==RUN), decoded from state register.
//  - count never wraps: advances only while count<limit_q<=2^WIDTH-1.
// STRUCTURE
//  - Shared package cnt_ctrl_pkg: state localparams (IDLE/RUN/PAUSED/DONE),
//    default WIDTH.
//  - Sub-module cnt_core: WIDTH-bit counter, async active-high reset,
//    falling-edge clock, inputs clr/en; clr dominates en. Controller holds
//    FSM, limit/mode regs, terminal compare, tick/done.
// TESTING
//  1 Reset: assert reset mid-RUN at count=5 -> count=0, tick=0, done=0,
//    cmd_ready=1 immediately (async); no tick after release.
//  2 One-shot: limit=3, periodic=0 -> count 0,1,2,3; tick on 4th RUN edge;
//    done=1 held, count=3; done_ack -> IDLE, count=0.
//  3 Periodic: limit=2, periodic=1 -> tick every 3 cycles over 4 periods;
//    done never asserts; cmd_ready=0 throughout.
//  4 Pause: limit=4, pause at count=4 for 3 cycles -> count holds 4, no
//    tick; release -> tick on next edge, then DONE.
//  5 Abort: abort in PAUSED and in DONE -> IDLE next edge, count=0, done=0;
//    abort+cmd_valid in IDLE -> not accepted.
//  6 Edges: limit=0 periodic -> tick every cycle; limit=255 one-shot ->
//    256-cycle run, no wrap.

Source files
------------

// File: rtl/cnt_ctrl_pkg.sv
// Shared definitions for the count sequencer: controller state codes and the
// default counter width.
package cnt_ctrl_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef logic [1:0] state_t;

    localparam state_t IDLE   = 2'b00;
    localparam state_t RUN    = 2'b01;
    localparam state_t PAUSED = 2'b10;
    localparam state_t DONE   = 2'b11;

endpackage

// File: rtl/cnt_core.sv
// Counter core driven only by the sequencer. Updates on the falling edge;
// clear takes precedence over enable.
module cnt_core
    import cnt_ctrl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    // Counter register: clear, increment or hold.
    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/count_seq_ctrl.sv
// Count sequencer: accepts a limit/mode command, runs the counter core from
// zero to the limit, and reports terminal count (tick) and one-shot
// completion (done, held until done_ack).
//
// state  | meaning
// IDLE   | waiting for a command; cmd_ready high
// RUN    | counting toward limit_q
// PAUSED | counter frozen by pause
// DONE   | one-shot finished; count parked at limit_q until done_ack
module count_seq_ctrl
    import cnt_ctrl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_limit,
    input  logic             cmd_periodic,
    input  logic             pause,
    input  logic             abort,
    input  logic             done_ack,
    output logic [WIDTH-1:0] count,
    output logic             tick,
    output logic             running,
    output logic             done
);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] limit_q;
    logic             periodic_q;
    logic             accept;
    logic             at_limit;
    logic             clr;
    logic             en;
    logic             tick_nxt;
    logic             done_nxt;

    // Abort in IDLE blocks acceptance even though cmd_ready stays high.
    assign cmd_ready = (state == IDLE);
    assign accept    = cmd_ready & cmd_valid & ~abort;
    assign at_limit  = (count == limit_q);
    assign running   = (state == RUN);

    cnt_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk   (clk),
        .reset (reset),
        .clr   (clr),
        .en    (en),
        .count (count)
    );

    // State, command and status registers.
    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            limit_q    <= '0;
            periodic_q <= 1'b0;
            tick       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state <= state_nxt;
            tick  <= tick_nxt;
            done  <= done_nxt;
            if (accept) begin
                limit_q    <= cmd_limit;
                periodic_q <= cmd_periodic;
            end
        end
    end

    // Next state: abort beats pause beats terminal/increment.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (pause) begin
                    state_nxt = PAUSED;
                end else if (at_limit && !periodic_q) begin
                    state_nxt = DONE;
                end
            end
            PAUSED: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (!pause) begin
                    state_nxt = RUN;
                end
            end
            DONE: begin
                if (abort || done_ack) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Counter control and next tick/done values for the current state.
    always_comb begin
        clr      = 1'b0;
        en       = 1'b0;
        tick_nxt = 1'b0;
        done_nxt = 1'b0;
        case (state)
            IDLE: begin
                clr = accept;
            end
            RUN: begin
                if (abort) begin
                    clr = 1'b1;
                end else if (pause) begin
                    // terminal deferred until the pause is released
                end else if (at_limit) begin
                    tick_nxt = 1'b1;
                    if (periodic_q) begin
                        clr = 1'b1;
                    end else begin
                        done_nxt = 1'b1;
                    end
                end else begin
                    en = 1'b1;
                end
            end
            PAUSED: begin
                clr = abort;
            end
            DONE: begin
                if (abort || done_ack) begin
                    clr = 1'b1;
                end else begin
                    done_nxt = 1'b1;
                end
            end
            default: clr = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_count_seq_ctrl.sv
// Bench for count_seq_ctrl: directed scenarios with literal expectations, then
// randomized traffic, all compared each cycle against a behavioural model.
module tb_count_seq_ctrl;

    localparam int W = 8;

    logic         clk = 1'b1;
    logic         reset;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [W-1:0] cmd_limit;
    logic         cmd_periodic;
    logic         pause;
    logic         abort;
    logic         done_ack;
    logic [W-1:0] count;
    logic         tick;
    logic         running;
    logic         done;

    int n_pass  = 0;
    int n_total = 0;

    count_seq_ctrl #(.WIDTH(W)) dut (
        .clk          (clk),
        .reset        (reset),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_limit    (cmd_limit),
        .cmd_periodic (cmd_periodic),
        .pause        (pause),
        .abort        (abort),
        .done_ack     (done_ack),
        .count        (count),
        .tick         (tick),
        .running      (running),
        .done         (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Behavioural model: busy = a command is in progress, paused/finished as
    // flags, count as a plain integer.
    bit m_busy, m_paused, m_fin, m_per, m_tick, m_done;
    int m_lim, m_cnt;

    always @(negedge clk or posedge reset) begin
        if (reset) begin
            m_busy = 0; m_paused = 0; m_fin = 0; m_per = 0;
            m_tick = 0; m_done = 0; m_lim = 0; m_cnt = 0;
        end else if (!m_busy && !m_fin) begin
            m_tick = 0;
            if (cmd_valid && !abort) begin
                m_lim = int'(cmd_limit); m_per = cmd_periodic;
                m_cnt = 0; m_busy = 1; m_paused = 0;
            end
        end else if (abort) begin
            m_busy = 0; m_paused = 0; m_fin = 0;
            m_cnt = 0; m_tick = 0; m_done = 0;
        end else if (m_fin) begin
            m_tick = 0;
            if (done_ack) begin
                m_fin = 0; m_done = 0; m_cnt = 0;
            end
        end else if (m_paused) begin
            m_tick = 0;
            if (!pause) m_paused = 0;
        end else if (pause) begin
            m_paused = 1; m_tick = 0;
        end else if (m_cnt == m_lim) begin
            m_tick = 1;
            if (m_per) m_cnt = 0;
            else begin
                m_busy = 0; m_fin = 1; m_done = 1;
            end
        end else begin
            m_cnt = m_cnt + 1; m_tick = 0;
        end
    end

    // Compare DUT against the model midway between falling edges.
    always @(posedge clk) begin
        if (!reset) begin
            n_total++;
            if (int'(count) == m_cnt && tick == m_tick && done == m_done &&
                running == (m_busy && !m_paused) && cmd_ready == (!m_busy && !m_fin))
                n_pass++;
            else
                $display("FAIL model: got cnt=%0d tick=%0b done=%0b run=%0b rdy=%0b, expected cnt=%0d tick=%0b done=%0b run=%0b rdy=%0b (t=%0t)",
                         count, tick, done, running, cmd_ready, m_cnt, m_tick, m_done,
                         m_busy && !m_paused, !m_busy && !m_fin, $time);
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic issue(input int lim, input bit per);
        cmd_valid = 1; cmd_limit = W'(lim); cmd_periodic = per;
        cyc(1);
        cmd_valid = 0;
    endtask

    initial begin
        int ticks, n, prev;
        bit saw_done, saw_ready, wrapped;

        reset = 1; cmd_valid = 0; cmd_limit = '0; cmd_periodic = 0;
        pause = 0; abort = 0; done_ack = 0;
        cyc(2);
        reset = 0;
        check("reset_ready", int'(cmd_ready), 1);
        check("reset_count", int'(count), 0);

        // one-shot, limit 3
        issue(3, 0);
        check("os_start_count", int'(count), 0);
        check("os_start_running", int'(running), 1);
        cyc(3);
        check("os_count3", int'(count), 3);
        check("os_no_tick_yet", int'(tick), 0);
        cyc(1);
        check("os_tick", int'(tick), 1);
        check("os_done", int'(done), 1);
        check("os_hold_count", int'(count), 3);
        cyc(2);
        check("os_tick_one_cycle", int'(tick), 0);
        check("os_done_held", int'(done), 1);
        check("os_not_ready", int'(cmd_ready), 0);
        done_ack = 1; cyc(1); done_ack = 0;
        check("os_ack_done", int'(done), 0);
        check("os_ack_count", int'(count), 0);
        check("os_ack_ready", int'(cmd_ready), 1);

        // periodic, limit 2: ticks every 3 cycles
        issue(2, 1);
        ticks = 0; saw_done = 0; saw_ready = 0;
        repeat (12) begin
            cyc(1);
            ticks += int'(tick);
            saw_done |= done;
            saw_ready |= cmd_ready;
        end
        check("per_ticks", ticks, 4);
        check("per_no_done", int'(saw_done), 0);
        check("per_not_ready", int'(saw_ready), 0);
        abort = 1; cyc(1); abort = 0;
        check("per_abort_ready", int'(cmd_ready), 1);

        // pause at the terminal count
        issue(4, 0);
        cyc(4);
        check("pause_pre_count", int'(count), 4);
        pause = 1;
        ticks = 0;
        repeat (3) begin cyc(1); ticks += int'(tick); end
        check("pause_no_tick", ticks, 0);
        check("pause_count_held", int'(count), 4);
        check("pause_not_running", int'(running), 0);
        pause = 0; cyc(1);
        check("resume_running", int'(running), 1);
        check("resume_no_tick", int'(tick), 0);
        cyc(1);
        check("resume_tick", int'(tick), 1);
        check("resume_done", int'(done), 1);
        done_ack = 1; cyc(1); done_ack = 0;

        // abort in PAUSED, in DONE, and in IDLE with a command offered
        issue(10, 0);
        cyc(2);
        pause = 1; cyc(1);
        abort = 1; cyc(1); abort = 0; pause = 0;
        check("abort_paused_ready", int'(cmd_ready), 1);
        check("abort_paused_count", int'(count), 0);
        issue(1, 0);
        cyc(2);
        check("abort_done_pre", int'(done), 1);
        abort = 1; cyc(1); abort = 0;
        check("abort_done_done", int'(done), 0);
        check("abort_done_count", int'(count), 0);
        abort = 1; cmd_valid = 1; cmd_limit = 8'd5; cyc(1);
        check("abort_idle_no_accept", int'(running), 0);
        check("abort_idle_ready", int'(cmd_ready), 1);
        abort = 0; cmd_valid = 0;

        // asynchronous reset mid-run
        issue(20, 0);
        cyc(5);
        check("rst_pre_count", int'(count), 5);
        #2 reset = 1;
        #1;
        check("rst_async_count", int'(count), 0);
        check("rst_async_tick", int'(tick), 0);
        check("rst_async_done", int'(done), 0);
        check("rst_async_ready", int'(cmd_ready), 1);
        cyc(1);
        reset = 0;
        ticks = 0;
        repeat (3) begin cyc(1); ticks += int'(tick); end
        check("rst_no_tick_after", ticks, 0);
        check("rst_idle", int'(running), 0);

        // limit 0 periodic: tick every cycle
        issue(0, 1);
        ticks = 0;
        repeat (8) begin cyc(1); ticks += int'(tick); end
        check("lim0_ticks", ticks, 8);
        abort = 1; cyc(1); abort = 0;

        // limit 255 one-shot: full-range run, no wrap
        issue(255, 0);
        n = 0; prev = 0; wrapped = 0;
        while (!tick && n < 400) begin
            cyc(1);
            n++;
            if (int'(count) < prev) wrapped = 1;
            prev = int'(count);
        end
        check("lim255_cycles", n, 256);
        check("lim255_no_wrap", int'(wrapped), 0);
        check("lim255_count", int'(count), 255);
        check("lim255_done", int'(done), 1);
        done_ack = 1; cyc(1); done_ack = 0;

        // randomized traffic, checked only by the model
        repeat (3000) begin
            cmd_valid    = ($urandom_range(0, 2) == 0);
            cmd_limit    = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 255))
                                                       : W'($urandom_range(0, 12));
            cmd_periodic = $urandom_range(0, 1) == 1;
            pause        = ($urandom_range(0, 7) == 0);
            abort        = ($urandom_range(0, 39) == 0);
            done_ack     = ($urandom_range(0, 3) == 0);
            cyc(1);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
